// File: rtl/al_accel_acc_matrix_pipe_if.sv
// Purpose: beat/result bundle between a producer/consumer and the accumulate pipe.
// Latency: none, this is wiring only.
// Backpressure: in_ready/out_ready carry the valid-ready handshakes in each direction.
interface al_accel_acc_matrix_pipe_if #(
    parameter int DW    = 32,
    parameter int LANES = 3,
    parameter int TERMS = 9
);
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_first;
    logic                       in_last;
    logic [LANES*DW-1:0]        bias;
    logic [LANES*TERMS*DW-1:0]  data;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*DW-1:0]        out_data;
    logic [LANES-1:0]           out_sat;
    logic [7:0]                 out_count;

    // Producer of beats and consumer of results.
    modport master (
        output in_valid, in_first, in_last, bias, data, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_count
    );

    // The accumulate pipe itself.
    modport slave (
        input  in_valid, in_first, in_last, bias, data, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_count
    );
endinterface

// File: rtl/al_accel_acc_matrix_pipe.sv
// Purpose: per-lane multi-term sum, accumulated across framed beats, with optional saturation.
// Latency: a closing beat accepted at edge N shows its result after edge N+2.
// Backpressure: whole pipe freezes while a result is held unconsumed or enb is low; in_ready follows.
module al_accel_acc_matrix_pipe #(
    parameter int DW    = 32,
    parameter int AW    = 40,
    parameter int LANES = 3,
    parameter int TERMS = 9,
    parameter int SAT   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enb,
    al_accel_acc_matrix_pipe_if.slave bus,
    output logic                      seq_err
);

    // Accumulator needs headroom for TERMS-way sums plus multi-beat growth.
    generate
        if (AW < DW + 8) begin : g_aw_check
            $error("al_accel_acc_matrix_pipe: AW must be at least DW+8");
        end
    endgenerate

    localparam logic [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic {
        ST_IDLE = 1'b0,   // no accumulation open
        ST_OPEN = 1'b1    // accumulation in progress
    } acc_state_e;

    function automatic logic [AW-1:0] sext(input logic [DW-1:0] v);
        sext = {{(AW-DW){v[DW-1]}}, v};
    endfunction

    // Global flow control: one enable moves every stage together.
    logic stall;
    logic advance;

    // Stage A: per-lane term sums plus framing tags.
    logic            a_vld_q;
    logic            a_first_q;
    logic            a_last_q;
    logic [AW-1:0]   a_bias_q [LANES];
    logic [AW-1:0]   a_sum_q  [LANES];
    logic [AW-1:0]   a_sum_d  [LANES];

    // Stage B: accumulators, beat counter, framing state.
    acc_state_e      st_q;
    acc_state_e      st_d;
    logic            eff_first;
    logic            framing_err;
    logic [AW-1:0]   acc_q [LANES];
    logic [AW-1:0]   acc_d [LANES];
    logic [7:0]      cnt_q;
    logic [7:0]      cnt_d;
    logic            b_res_q;
    logic            seq_err_q;

    // Output stage.
    logic                out_valid_q;
    logic [LANES*DW-1:0] out_data_q;
    logic [LANES*DW-1:0] res_dat_d;
    logic [LANES-1:0]    out_sat_q;
    logic [LANES-1:0]    res_sat_d;
    logic [7:0]          out_count_q;

    assign stall        = out_valid_q & ~bus.out_ready;
    assign advance      = enb & ~stall;
    assign bus.in_ready = advance;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_count = out_count_q;
    assign seq_err       = seq_err_q;

    // Sign-extended TERMS-way sum per lane of the incoming beat.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            a_sum_d[l] = '0;
            for (int t = 0; t < TERMS; t++) begin
                a_sum_d[l] = a_sum_d[l] + sext(bus.data[(l*TERMS+t)*DW +: DW]);
            end
        end
    end

    // Stage A register: capture sums and tags of an accepted beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_vld_q   <= 1'b0;
            a_first_q <= 1'b0;
            a_last_q  <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                a_bias_q[l] <= '0;
                a_sum_q[l]  <= '0;
            end
        end else if (advance) begin
            a_vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                a_first_q <= bus.in_first;
                a_last_q  <= bus.in_last;
                for (int l = 0; l < LANES; l++) begin
                    a_bias_q[l] <= sext(bus.bias[l*DW +: DW]);
                    a_sum_q[l]  <= a_sum_d[l];
                end
            end
        end
    end

    // Framing FSM and accumulate: a beat with no open accumulation is
    // treated as a first beat; a first beat over an open one restarts it.
    always_comb begin
        st_d        = st_q;
        eff_first   = a_first_q | (st_q == ST_IDLE);
        framing_err = 1'b0;
        cnt_d       = cnt_q;
        for (int l = 0; l < LANES; l++) begin
            acc_d[l] = (eff_first ? a_bias_q[l] : acc_q[l]) + a_sum_q[l];
        end
        if (a_vld_q) begin
            framing_err = a_first_q ^ (st_q == ST_IDLE);
            st_d        = a_last_q ? ST_IDLE : ST_OPEN;
            if (eff_first) begin
                cnt_d = 8'd1;
            end else if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Stage B register: accumulator state, beat count and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q      <= ST_IDLE;
            cnt_q     <= '0;
            b_res_q   <= 1'b0;
            seq_err_q <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= '0;
            end
        end else if (advance) begin
            st_q      <= st_d;
            b_res_q   <= a_vld_q & a_last_q;
            seq_err_q <= seq_err_q | framing_err;
            if (a_vld_q) begin
                cnt_q <= cnt_d;
                for (int l = 0; l < LANES; l++) begin
                    acc_q[l] <= acc_d[l];
                end
            end
        end
    end

    // Narrow the accumulator to DW, clamping when saturation is enabled.
    always_comb begin
        res_dat_d = '0;
        res_sat_d = '0;
        for (int l = 0; l < LANES; l++) begin
            if ((SAT != 0) && ($signed(acc_q[l]) > $signed(SAT_MAX))) begin
                res_dat_d[l*DW +: DW] = SAT_MAX[DW-1:0];
                res_sat_d[l]          = 1'b1;
            end else if ((SAT != 0) && ($signed(acc_q[l]) < $signed(SAT_MIN))) begin
                res_dat_d[l*DW +: DW] = SAT_MIN[DW-1:0];
                res_sat_d[l]          = 1'b1;
            end else begin
                res_dat_d[l*DW +: DW] = acc_q[l][DW-1:0];
            end
        end
    end

    // Output register: advance only happens when the held result is
    // absent or being consumed, so valid simply follows the new result.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
            out_count_q <= '0;
        end else if (advance) begin
            out_valid_q <= b_res_q;
            if (b_res_q) begin
                out_data_q  <= res_dat_d;
                out_sat_q   <= res_sat_d;
                out_count_q <= cnt_q;
            end
        end
    end

endmodule

// File: tb/tb_al_accel_acc_matrix_pipe.sv
// Purpose: self-checking bench for the accumulate pipe against a beat-level reference model.
// Latency: checks the two-edge result latency on a quiet pipe.
// Backpressure: exercises held results, enb gating and random out_ready.
module tb_al_accel_acc_matrix_pipe;
    localparam int DW    = 32;
    localparam int AW    = 40;
    localparam int LANES = 3;
    localparam int TERMS = 9;
    localparam longint MAXP = (longint'(1) << (DW-1)) - 1;
    localparam longint MINN = -(longint'(1) << (DW-1));

    logic clk = 1'b0;
    logic reset;
    logic enb;
    logic seq_err;

    always #5 clk = ~clk;

    al_accel_acc_matrix_pipe_if #(.DW(DW), .LANES(LANES), .TERMS(TERMS)) bus ();

    al_accel_acc_matrix_pipe #(
        .DW(DW), .AW(AW), .LANES(LANES), .TERMS(TERMS), .SAT(1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enb     (enb),
        .bus     (bus),
        .seq_err (seq_err)
    );

    typedef struct {
        logic [LANES*DW-1:0] dat;
        logic [LANES-1:0]    sat;
        logic [7:0]          cnt;
    } res_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    res_t   exp_q[$];
    longint m_acc [LANES];
    bit     m_open;
    int     m_cnt;
    bit     m_err;
    bit     hold_v = 1'b0;
    res_t   held;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input logic [DW-1:0] v);
        longint r;
        r = $signed(v);
        return r;
    endfunction

    function automatic longint wrap_aw(input longint v);
        return (v <<< (64-AW)) >>> (64-AW);
    endfunction

    task automatic model_clear();
        exp_q.delete();
        for (int l = 0; l < LANES; l++) m_acc[l] = 0;
        m_open = 1'b0;
        m_cnt  = 0;
        m_err  = 1'b0;
        hold_v = 1'b0;
    endtask

    // Reference: apply one accepted beat at the transaction level.
    task automatic model_accept();
        bit          ef;
        longint      s;
        logic [63:0] tmp;
        res_t        r;
        ef = bus.in_first || !m_open;
        if (bus.in_first == m_open) m_err = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            s = 0;
            for (int t = 0; t < TERMS; t++) s += sx(bus.data[(l*TERMS+t)*DW +: DW]);
            if (ef) m_acc[l] = sx(bus.bias[l*DW +: DW]) + s;
            else    m_acc[l] = m_acc[l] + s;
            m_acc[l] = wrap_aw(m_acc[l]);
        end
        m_cnt  = ef ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        m_open = !bus.in_last;
        if (bus.in_last) begin
            r.dat = '0;
            r.sat = '0;
            for (int l = 0; l < LANES; l++) begin
                if (m_acc[l] > MAXP) begin
                    tmp = MAXP;
                    r.sat[l] = 1'b1;
                end else if (m_acc[l] < MINN) begin
                    tmp = MINN;
                    r.sat[l] = 1'b1;
                end else begin
                    tmp = m_acc[l];
                end
                r.dat[l*DW +: DW] = tmp[DW-1:0];
            end
            r.cnt = 8'(m_cnt);
            exp_q.push_back(r);
        end
    endtask

    // One clock: observe at negedge, then advance past the rising edge.
    task automatic step();
        res_t r;
        @(negedge clk);
        if (!reset) begin
            check_val("in_ready_rule", bus.in_ready, enb & ~(bus.out_valid & ~bus.out_ready));
            if (hold_v) begin
                check_val("hold_valid", bus.out_valid, 1'b1);
                check_val("hold_data",  bus.out_data,  held.dat);
                check_val("hold_sat",   bus.out_sat,   held.sat);
                check_val("hold_count", bus.out_count, held.cnt);
            end
            if (bus.out_valid && bus.out_ready && enb) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_result", bus.out_valid, 1'b0);
                end else begin
                    r = exp_q.pop_front();
                    check_val("res_data",  bus.out_data,  r.dat);
                    check_val("res_sat",   bus.out_sat,   r.sat);
                    check_val("res_count", bus.out_count, r.cnt);
                end
                hold_v = 1'b0;
            end else if (bus.out_valid) begin
                hold_v   = 1'b1;
                held.dat = bus.out_data;
                held.sat = bus.out_sat;
                held.cnt = bus.out_count;
            end else begin
                hold_v = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) model_accept();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        check_val("rst_out_valid", bus.out_valid, 1'b0);
        check_val("rst_out_data",  bus.out_data,  '0);
        check_val("rst_out_sat",   bus.out_sat,   '0);
        check_val("rst_out_count", bus.out_count, '0);
        check_val("rst_seq_err",   seq_err,       1'b0);
        check_val("rst_in_ready",  bus.in_ready,  enb);
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        enb           = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() > 0 || bus.out_valid); i++) step();
        check_val("drain_pending", exp_q.size(), 0);
        check_val("drain_out_valid", bus.out_valid, 1'b0);
    endtask

    task automatic fill(input logic [DW-1:0] v0, input logic [DW-1:0] v1, input logic [DW-1:0] v2);
        for (int t = 0; t < TERMS; t++) begin
            bus.data[(0*TERMS+t)*DW +: DW] = v0;
            bus.data[(1*TERMS+t)*DW +: DW] = v1;
            bus.data[(2*TERMS+t)*DW +: DW] = v2;
        end
    endtask

    task automatic beat(input bit first, input bit last);
        bus.in_valid = 1'b1;
        bus.in_first = first;
        bus.in_last  = last;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        enb          = 1'b1;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.bias     = '0;
        bus.data     = '0;
        do_reset();

        // Single beat, latency of two edges.
        bus.out_ready = 1'b1;
        bus.bias = {32'd30, 32'd20, 32'd10};
        fill(32'd1, 32'd2, -32'sd3);
        beat(1'b1, 1'b1);
        check_val("lat_edge0", bus.out_valid, 1'b0);
        step();
        check_val("lat_edge1", bus.out_valid, 1'b0);
        step();
        check_val("lat_edge2", bus.out_valid, 1'b1);
        check_val("single_data", bus.out_data, {32'd3, 32'd38, 32'd19});
        check_val("single_sat", bus.out_sat, 3'b000);
        check_val("single_cnt", bus.out_count, 8'd1);
        drain();
        check_val("seq_err_clean", seq_err, 1'b0);

        // Three-beat accumulation.
        bus.bias = '0;
        fill(32'd100, 32'd0, 32'd0);
        beat(1'b1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        step();
        bus.in_last = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        check_val("multi_early", bus.out_valid, 1'b0);
        step();
        check_val("multi_valid", bus.out_valid, 1'b1);
        check_val("multi_lane0", bus.out_data[DW-1:0], 32'd2700);
        check_val("multi_cnt", bus.out_count, 8'd3);
        drain();

        // Saturation, both directions, back to back.
        bus.bias = {32'd0, 32'd0, 32'h7FFF_FFF0};
        fill(32'h10, 32'd0, 32'd0);
        beat(1'b1, 1'b1);
        bus.bias = {32'd0, 32'd0, 32'h8000_0010};
        fill(32'hFFFF_FFF0, 32'd0, 32'd0);
        beat(1'b1, 1'b1);
        step();
        check_val("satp_lane0", bus.out_data[DW-1:0], 32'h7FFF_FFFF);
        check_val("satp_flag", bus.out_sat[0], 1'b1);
        step();
        check_val("satn_lane0", bus.out_data[DW-1:0], 32'h8000_0000);
        check_val("satn_flag", bus.out_sat[0], 1'b1);
        drain();

        // Backpressure: held result blocks input.
        bus.out_ready = 1'b0;
        bus.bias = {32'd3, 32'd2, 32'd1};
        fill(32'd4, 32'd5, 32'd6);
        beat(1'b1, 1'b1);
        step();
        step();
        check_val("bp_valid", bus.out_valid, 1'b1);
        bus.bias = {32'd9, 32'd8, 32'd7};
        bus.in_valid = 1'b1;
        bus.in_first = 1'b1;
        bus.in_last  = 1'b1;
        check_val("bp_in_ready_lo", bus.in_ready, 1'b0);
        repeat (3) step();
        check_val("bp_still_lo", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        check_val("bp_in_ready_hi", bus.in_ready, 1'b1);
        step();
        drain();

        // Framing error after reset.
        do_reset();
        bus.out_ready = 1'b1;
        bus.bias = {32'd7, 32'd6, 32'd5};
        fill(32'd1, 32'd1, 32'd1);
        beat(1'b0, 1'b1);
        drain();
        check_val("seq_err_set", seq_err, 1'b1);
        beat(1'b1, 1'b1);
        drain();
        check_val("seq_err_sticky", seq_err, 1'b1);

        // Reset in mid accumulation discards prior beats.
        do_reset();
        bus.out_ready = 1'b1;
        bus.bias = '0;
        fill(32'd100, 32'd0, 32'd0);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        do_reset();
        bus.out_ready = 1'b1;
        repeat (3) step();
        bus.bias = {32'd0, 32'd0, 32'd7};
        fill(32'd1, 32'd0, 32'd0);
        beat(1'b1, 1'b1);
        step();
        step();
        check_val("post_rst_lane0", bus.out_data[DW-1:0], 32'd16);
        check_val("post_rst_cnt", bus.out_count, 8'd1);
        drain();

        // Beat counter saturates at 255.
        bus.bias = '0;
        fill(32'd1, 32'd0, 32'd0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.in_first = (i == 0);
            bus.in_last  = (i == 299);
            step();
        end
        bus.in_valid = 1'b0;
        drain();

        // Randomized traffic with enb gating and random backpressure.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            enb           = ($urandom % 8) != 0;
            bus.out_ready = ($urandom % 4) != 0;
            bus.in_valid  = ($urandom % 4) != 0;
            bus.in_first  = ($urandom % 3) == 0;
            bus.in_last   = ($urandom % 3) == 0;
            for (int l = 0; l < LANES; l++)
                bus.bias[l*DW +: DW] = (($urandom % 4) == 0) ? DW'($urandom) : DW'($urandom_range(0, 4000)) - DW'(2000);
            for (int k = 0; k < LANES*TERMS; k++)
                bus.data[k*DW +: DW] = (($urandom % 6) == 0) ? DW'($urandom) : DW'($urandom_range(0, 2000)) - DW'(1000);
            step();
        end
        drain();
        check_val("rand_seq_err", seq_err, m_err);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
